// File: rtl/cpu_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and imem (slave).
interface cpu_fetch_unit_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   imem_req;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic                   imem_gnt;
    logic                   imem_rvalid;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/cpu_fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, prefetch FIFO, branch redirect.
// Optional performance counters are enabled with `define CPU_FETCH_PERF_EN.
module cpu_fetch_unit #(
    parameter int                  ADDR_WIDTH  = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_RESET  = '0,
    parameter int                  FIFO_DEPTH  = 2,
    parameter int                  PC_INC      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cpu_fetch_unit_if.master       imem,
    input  logic                   br_taken,
    input  logic [ADDR_WIDTH-1:0]  br_target,
    input  logic                   stall,
    output logic                   if_valid,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [ADDR_WIDTH-1:0]  if_pc,
    output logic                   if_pipe_en
`ifdef CPU_FETCH_PERF_EN
    ,
    output logic [31:0]            perf_fetch_cnt,
    output logic [31:0]            perf_flush_cnt
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

    state_t                 state, state_nx;
    logic [ADDR_WIDTH-1:0]  pc, pc_nx, req_pc, req_pc_nx;
    logic                   hold_off, hold_off_nx;
    logic [ADDR_WIDTH-1:0]  fifo_pc    [FIFO_DEPTH];
    logic [INSTR_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
    logic [PW-1:0]          rd_ptr, wr_ptr;
    logic [CW-1:0]          count, count_nx;
    logic                   push, pop, gnt_ok, not_empty;

    // hold_off withdraws imem_req for the cycle after a redirect caught an ungranted request
    always_comb begin
        imem.imem_req  = (state == REQ) && !hold_off;
        imem.imem_addr = pc;
        gnt_ok         = imem.imem_req && imem.imem_gnt;
        not_empty      = (count != '0);
        if_pipe_en     = !stall;
        if_valid       = not_empty && !br_taken;
        if_instr       = not_empty ? fifo_instr[rd_ptr] : '0;
        if_pc          = not_empty ? fifo_pc[rd_ptr]    : '0;
        pop            = if_valid && !stall;
        push           = (state == WAIT) && imem.imem_rvalid && !br_taken;
        count_nx       = br_taken ? '0 : (count + CW'(push) - CW'(pop));
    end

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        req_pc_nx   = req_pc;
        hold_off_nx = 1'b0;
        case (state)
            IDLE: begin
                if (br_taken) begin
                    pc_nx    = br_target;
                    state_nx = REQ;
                end else if (count < DEPTH_C) begin
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (gnt_ok) begin
                    req_pc_nx = pc;
                    pc_nx     = pc + ADDR_WIDTH'(PC_INC);
                    state_nx  = WAIT;
                end
                if (br_taken) begin
                    pc_nx       = br_target;
                    state_nx    = gnt_ok ? DISCARD : REQ;
                    hold_off_nx = !gnt_ok;
                end
            end
            WAIT: begin
                if (br_taken) begin
                    pc_nx    = br_target;
                    state_nx = imem.imem_rvalid ? REQ : DISCARD;
                end else if (imem.imem_rvalid) begin
                    state_nx = (count_nx < DEPTH_C) ? REQ : IDLE;
                end
            end
            DISCARD: begin
                if (br_taken) pc_nx = br_target;
                if (imem.imem_rvalid) state_nx = REQ;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= PC_RESET;
            req_pc   <= PC_RESET;
            hold_off <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            req_pc   <= req_pc_nx;
            hold_off <= hold_off_nx;
            count    <= count_nx;
            if (br_taken) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= req_pc;
            fifo_instr[wr_ptr] <= imem.imem_rdata;
        end
    end

`ifdef CPU_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pop)      perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (br_taken) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) push |-> (count < DEPTH_C));

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Self-checking bench for cpu_fetch_unit: randomized imem responder plus an instruction-stream model.
module tb_cpu_fetch_unit;
    logic        clk;
    logic        rst_n;
    logic        br_taken;
    logic [31:0] br_target;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_pipe_en;
`ifdef CPU_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    cpu_fetch_unit_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) mem_if ();

    cpu_fetch_unit #(
        .ADDR_WIDTH(32), .INSTR_WIDTH(32), .PC_RESET(32'h0), .FIFO_DEPTH(2), .PC_INC(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem       (mem_if.master),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .stall      (stall),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_pipe_en (if_pipe_en)
`ifdef CPU_FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // imem responder state
    int          gnt_pct = 100;
    int          lat_lo  = 1;
    int          lat_hi  = 1;
    bit          pend_valid;
    int          pend_cnt;
    logic [31:0] pend_addr;
    bit          force_en;
    logic [31:0] force_data;

    // observations collected each cycle
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];
    logic [31:0] got_addr[$];
    bit          saw_poison;
    logic        last_if_valid;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One clock: drive the memory side, sample what the coming posedge commits, move to next negedge.
    task automatic tick();
        if (pend_valid && pend_cnt == 0) begin
            mem_if.imem_rvalid = 1'b1;
            mem_if.imem_rdata  = force_en ? force_data : word(pend_addr);
            force_en   = 1'b0;
            pend_valid = 1'b0;
        end else begin
            mem_if.imem_rvalid = 1'b0;
            mem_if.imem_rdata  = $urandom;
            if (pend_valid) pend_cnt--;
        end
        mem_if.imem_gnt = 1'b0;
        #1;
        if (mem_if.imem_req && ($urandom_range(0, 99) < gnt_pct)) begin
            mem_if.imem_gnt = 1'b1;
            pend_valid = 1'b1;
            pend_addr  = mem_if.imem_addr;
            pend_cnt   = $urandom_range(lat_lo, lat_hi) - 1;
        end
        #1;
        if (mem_if.imem_req && mem_if.imem_gnt && !br_taken) got_addr.push_back(mem_if.imem_addr);
        if (if_valid && !stall) begin
            got_pc.push_back(if_pc);
            got_instr.push_back(if_instr);
        end
        if (if_valid && if_instr == 32'hDEAD_BEEF) saw_poison = 1'b1;
        last_if_valid = if_valid;
        @(negedge clk);
    endtask

    task automatic clear_obs();
        got_pc.delete();
        got_instr.delete();
        got_addr.delete();
        saw_poison = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        br_taken = 1'b0;
        stall    = 1'b0;
        tick();
        tick();
        pend_valid = 1'b0;
        force_en   = 1'b0;
        clear_obs();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; br_taken = 1'b0; stall = 1'b0;
        tick();
        tick();
        total++; if (if_valid !== 1'b0)       begin bad++; $display("FAIL reset_if_valid got=%b exp=0", if_valid); end
        total++; if (mem_if.imem_req !== 1'b0) begin bad++; $display("FAIL reset_imem_req got=%b exp=0", mem_if.imem_req); end
        total++; if (mem_if.imem_addr !== 32'h0) begin bad++; $display("FAIL reset_imem_addr got=%h exp=0", mem_if.imem_addr); end
        total++; if (if_instr !== 32'h0)      begin bad++; $display("FAIL reset_if_instr got=%h exp=0", if_instr); end
        total++; if (if_pc !== 32'h0)         begin bad++; $display("FAIL reset_if_pc got=%h exp=0", if_pc); end
        total++; if (if_pipe_en !== 1'b1)     begin bad++; $display("FAIL reset_pipe_en got=%b exp=1", if_pipe_en); end
        stall = 1'b1;
        #1;
        total++; if (if_pipe_en !== 1'b0)     begin bad++; $display("FAIL stall_pipe_en got=%b exp=0", if_pipe_en); end
        stall = 1'b0;
    endtask

    task automatic test_free_run();
        int first;
        gnt_pct = 100; lat_lo = 1; lat_hi = 1;
        do_reset();
        first = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (first < 0 && got_pc.size() > 0) first = i;
        end
        total++; if (first < 0 || first > 3) begin bad++; $display("FAIL first_valid_latency got=%0d exp<=3", first); end
        total++; if (got_pc.size() < 15) begin bad++; $display("FAIL free_run_pops got=%0d exp>=15", got_pc.size()); end
        for (int i = 0; i < got_pc.size(); i++) begin
            total++; if (got_pc[i] !== 32'(i * 4)) begin bad++; $display("FAIL free_run_pc[%0d] got=%h exp=%h", i, got_pc[i], 32'(i * 4)); end
            total++; if (got_instr[i] !== word(32'(i * 4))) begin bad++; $display("FAIL free_run_instr[%0d] got=%h exp=%h", i, got_instr[i], word(32'(i * 4))); end
        end
        for (int i = 0; i < got_addr.size(); i++) begin
            total++; if (got_addr[i] !== 32'(i * 4)) begin bad++; $display("FAIL free_run_addr[%0d] got=%h exp=%h", i, got_addr[i], 32'(i * 4)); end
        end
    endtask

    task automatic test_stall_fill();
        int n;
        gnt_pct = 100; lat_lo = 1; lat_hi = 1;
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        total++; if (mem_if.imem_req !== 1'b0) begin bad++; $display("FAIL stall_req_idle got=%b exp=0", mem_if.imem_req); end
        total++; if (got_addr.size() != 2) begin bad++; $display("FAIL stall_fetch_count got=%0d exp=2", got_addr.size()); end
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin bad++; $display("FAIL stall_head got=%b/%h exp=1/0", if_valid, if_pc); end
        stall = 1'b0;
        clear_obs();
        tick();
        tick();
        total++; if (got_pc.size() != 2) begin bad++; $display("FAIL release_pops got=%0d exp=2", got_pc.size()); end
        else begin
            total++; if (got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4) begin bad++; $display("FAIL release_order got=%h,%h exp=0,4", got_pc[0], got_pc[1]); end
        end
        n = 0;
        while (got_addr.size() == 0 && n < 20) begin tick(); n++; end
        total++; if (got_addr.size() == 0) begin bad++; $display("FAIL resume_timeout got=none exp=8"); end
        else if (got_addr[0] !== 32'h8) begin bad++; $display("FAIL resume_addr got=%h exp=8", got_addr[0]); end
    endtask

    task automatic test_redirect_wait();
        int n;
        gnt_pct = 100; lat_lo = 3; lat_hi = 3;
        do_reset();
        n = 0;
        while (got_addr.size() < 3 && n < 50) begin tick(); n++; end
        total++; if (got_addr.size() < 3) begin bad++; $display("FAIL redirect_wait_setup got=%0d exp=3", got_addr.size()); end
        br_taken = 1'b1; br_target = 32'h100;
        force_en = 1'b1; force_data = 32'hDEAD_BEEF;
        clear_obs();
        tick();
        br_taken = 1'b0;
        total++; if (last_if_valid !== 1'b0) begin bad++; $display("FAIL redirect_valid_forced got=%b exp=0", last_if_valid); end
        clear_obs();
        for (int i = 0; i < 30; i++) tick();
        total++; if (saw_poison) begin bad++; $display("FAIL stale_visible got=DEADBEEF exp=absent"); end
        total++; if (got_addr.size() == 0 || got_addr[0] !== 32'h100) begin bad++; $display("FAIL redirect_req_addr got=%h exp=100", got_addr.size() ? got_addr[0] : 32'hx); end
        total++; if (got_pc.size() == 0 || got_pc[0] !== 32'h100) begin bad++; $display("FAIL redirect_first_pc got=%h exp=100", got_pc.size() ? got_pc[0] : 32'hx); end
        lat_lo = 1; lat_hi = 1;
    endtask

    task automatic test_redirect_rvalid_pop();
        int n;
        gnt_pct = 100; lat_lo = 1; lat_hi = 1;
        do_reset();
        stall = 1'b1;
        n = 0;
        while (got_addr.size() < 2 && n < 20) begin tick(); n++; end
        total++; if (if_valid !== 1'b1 || got_addr.size() != 2) begin bad++; $display("FAIL same_cycle_setup got=%b/%0d exp=1/2", if_valid, got_addr.size()); end
        stall = 1'b0; br_taken = 1'b1; br_target = 32'h200;
        clear_obs();
        tick();
        br_taken = 1'b0;
        #1;
        total++; if (got_pc.size() != 0) begin bad++; $display("FAIL same_cycle_pop got=%0d exp=0", got_pc.size()); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL same_cycle_flush got=%b exp=0", if_valid); end
        total++; if (mem_if.imem_req !== 1'b1 || mem_if.imem_addr !== 32'h200) begin bad++; $display("FAIL same_cycle_req got=%b/%h exp=1/200", mem_if.imem_req, mem_if.imem_addr); end
        for (int i = 0; i < 6; i++) tick();
        total++; if (got_pc.size() == 0 || got_pc[0] !== 32'h200) begin bad++; $display("FAIL same_cycle_next_pc got=%h exp=200", got_pc.size() ? got_pc[0] : 32'hx); end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] exp [4];
        exp[0] = 32'hFFFF_FFF8; exp[1] = 32'hFFFF_FFFC; exp[2] = 32'h0; exp[3] = 32'h4;
        gnt_pct = 100; lat_lo = 1; lat_hi = 1;
        do_reset();
        br_taken = 1'b1; br_target = 32'hFFFF_FFF8;
        tick();
        br_taken = 1'b0;
        clear_obs();
        for (int i = 0; i < 16; i++) tick();
        for (int i = 0; i < 4; i++) begin
            total++; if (got_addr.size() <= i || got_addr[i] !== exp[i]) begin bad++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, got_addr.size() > i ? got_addr[i] : 32'hx, exp[i]); end
            total++; if (got_pc.size() <= i || got_pc[i] !== exp[i]) begin bad++; $display("FAIL wrap_pc[%0d] got=%h exp=%h", i, got_pc.size() > i ? got_pc[i] : 32'hx, exp[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, exp_addr;
        int pops, errs;
        gnt_pct = 70; lat_lo = 1; lat_hi = 3;
        do_reset();
        exp_pc = 32'h0; exp_addr = 32'h0; pops = 0; errs = 0;
        for (int it = 0; it < 600; it++) begin
            br_taken  = ($urandom_range(0, 15) == 0);
            br_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
            stall     = ($urandom_range(0, 3) == 0);
            clear_obs();
            tick();
            foreach (got_pc[k]) begin
                pops++;
                total++; if (got_pc[k] !== exp_pc || got_instr[k] !== word(exp_pc)) begin
                    bad++; errs++;
                    if (errs < 10) $display("FAIL rand_pop it=%0d got=%h/%h exp=%h/%h", it, got_pc[k], got_instr[k], exp_pc, word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
            end
            foreach (got_addr[k]) begin
                total++; if (got_addr[k] !== exp_addr) begin
                    bad++; errs++;
                    if (errs < 10) $display("FAIL rand_addr it=%0d got=%h exp=%h", it, got_addr[k], exp_addr);
                end
                exp_addr = exp_addr + 32'd4;
            end
            if (br_taken) begin
                exp_pc   = br_target;
                exp_addr = br_target;
            end
        end
        br_taken = 1'b0; stall = 1'b0;
        total++; if (pops < 50) begin bad++; $display("FAIL rand_progress got=%0d exp>=50", pops); end
    endtask

`ifdef CPU_FETCH_PERF_EN
    task automatic test_perf();
        int pops;
        gnt_pct = 100; lat_lo = 1; lat_hi = 1;
        do_reset();
        total++; if (perf_fetch_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin bad++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", perf_fetch_cnt, perf_flush_cnt); end
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            br_taken  = (i == 8 || i == 14);
            br_target = 32'h40;
            clear_obs();
            tick();
            pops += got_pc.size();
        end
        br_taken = 1'b0;
        #1;
        total++; if (perf_fetch_cnt !== 32'(pops)) begin bad++; $display("FAIL perf_fetch got=%0d exp=%0d", perf_fetch_cnt, pops); end
        total++; if (perf_flush_cnt !== 32'd2) begin bad++; $display("FAIL perf_flush got=%0d exp=2", perf_flush_cnt); end
        rst_n = 1'b0;
        tick();
        #1;
        total++; if (perf_fetch_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin bad++; $display("FAIL perf_clear got=%0d/%0d exp=0/0", perf_fetch_cnt, perf_flush_cnt); end
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        rst_n = 1'b0; br_taken = 1'b0; br_target = '0; stall = 1'b0;
        mem_if.imem_gnt = 1'b0; mem_if.imem_rvalid = 1'b0; mem_if.imem_rdata = '0;
        pend_valid = 1'b0; pend_cnt = 0; pend_addr = '0; force_en = 1'b0; force_data = '0;
        saw_poison = 1'b0; last_if_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_free_run();
        test_stall_fill();
        test_redirect_wait();
        test_redirect_rvalid_pop();
        test_pc_wrap();
        test_random();
`ifdef CPU_FETCH_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
